// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencing controller: FETCH/DECODE/EXEC/MEM/WB/TRAP with a
// shared req/ready memory port, per-cycle datapath enables and timeout/illegal traps.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic       alusrc,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       branch,
   output logic       retire,
   output logic       illegal,
   output logic       bus_err,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_LOAD, C_STORE, C_IALU, C_BR, C_ILL
   } cls_t;

   state_t           r_state, w_next;
   cls_t             r_cls, w_cls;
   logic [CNT_W-1:0] r_cnt;
   logic             r_illegal, r_bus_err;
   logic             w_req, w_timeout;

   always_comb begin
      w_cls = C_ILL;
      unique case (opcode)
         7'b0110011: w_cls = C_R;
         7'b0000011: w_cls = C_LOAD;
         7'b0100011: w_cls = C_STORE;
         7'b0010011: w_cls = C_IALU;
         7'b1100011: w_cls = C_BR;
         default:    w_cls = C_ILL;
      endcase
   end

   // A non-zero wait count in FETCH means a fetch is outstanding, so it holds without run.
   assign w_req     = ((r_state == S_FETCH) && (run || (r_cnt != '0))) || (r_state == S_MEM);
   assign w_timeout = w_req && !mem_ready && (r_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_cls     <= C_R;
         r_cnt     <= '0;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_cls <= w_cls;
            if (w_cls == C_ILL) r_illegal <= 1'b1;
         end
         if (w_timeout) r_bus_err <= 1'b1;
         if (w_req && !mem_ready && (w_next == r_state)) r_cnt <= r_cnt + 1'b1;
         else                                            r_cnt <= '0;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_FETCH: begin
            if (w_timeout)                 w_next = S_TRAP;
            else if (w_req && mem_ready)   w_next = S_DECODE;
         end
         S_DECODE: w_next = (w_cls == C_ILL) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            unique case (r_cls)
               C_BR:            w_next = S_FETCH;
               C_LOAD, C_STORE: w_next = S_MEM;
               default:         w_next = S_WB;
            endcase
         end
         S_MEM: begin
            if (w_timeout)      w_next = S_TRAP;
            else if (mem_ready) w_next = (r_cls == C_STORE) ? S_FETCH : S_WB;
         end
         S_WB:    w_next = S_FETCH;
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
   end

   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      alusrc       = 1'b0;
      memtoreg     = 1'b0;
      regwrite     = 1'b0;
      branch       = 1'b0;
      retire       = 1'b0;
      illegal      = 1'b0;
      bus_err      = 1'b0;
      halted       = 1'b0;
      if (!rst) begin
         illegal = r_illegal;
         bus_err = r_bus_err;
         unique case (r_state)
            S_FETCH: begin
               mem_req = w_req;
               ir_we   = w_req && mem_ready;
               pc_we   = w_req && mem_ready;
            end
            S_EXEC: begin
               alusrc = (r_cls == C_LOAD) || (r_cls == C_STORE) || (r_cls == C_IALU);
               if (r_cls == C_BR) begin
                  branch = 1'b1;
                  pc_we  = 1'b1;
                  retire = 1'b1;
               end
            end
            S_MEM: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               alusrc       = 1'b1;
               mem_we       = (r_cls == C_STORE);
               retire       = (r_cls == C_STORE) && mem_ready;
            end
            S_WB: begin
               regwrite = 1'b1;
               retire   = 1'b1;
               memtoreg = (r_cls == C_LOAD);
            end
            S_TRAP:  halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each step queues the expected output vector,
// and a checker pops and compares it mid-cycle.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_BAD   = 7'b0110111;

   localparam logic [12:0] NONE = 13'h0000;
   localparam logic [12:0] REQ  = 13'h1000;
   localparam logic [12:0] WE   = 13'h0800;
   localparam logic [12:0] ASEL = 13'h0400;
   localparam logic [12:0] IRW  = 13'h0200;
   localparam logic [12:0] PCW  = 13'h0100;
   localparam logic [12:0] ALUS = 13'h0080;
   localparam logic [12:0] M2R  = 13'h0040;
   localparam logic [12:0] RW   = 13'h0020;
   localparam logic [12:0] BRN  = 13'h0010;
   localparam logic [12:0] RET  = 13'h0008;
   localparam logic [12:0] ILL  = 13'h0004;
   localparam logic [12:0] BERR = 13'h0002;
   localparam logic [12:0] HLT  = 13'h0001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [6:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alusrc, memtoreg;
   logic       regwrite, branch, retire, illegal, bus_err, halted;
   logic [12:0] w_obs;

   always #5 clk = ~clk;

   multicycle_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_we(ir_we), .pc_we(pc_we), .alusrc(alusrc), .memtoreg(memtoreg),
      .regwrite(regwrite), .branch(branch), .retire(retire),
      .illegal(illegal), .bus_err(bus_err), .halted(halted)
   );

   assign w_obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alusrc, memtoreg,
                   regwrite, branch, retire, illegal, bus_err, halted};

   typedef struct {
      logic [12:0] exp;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic st(input logic r, input logic rn, input logic [6:0] op,
                     input logic rdy, input logic [12:0] e, input string tag);
      exp_t t;
      @(negedge clk);
      rst       = r;
      run       = rn;
      opcode    = op;
      mem_ready = rdy;
      t.exp = e;
      t.tag = tag;
      sb.push_back(t);
   endtask

   always @(negedge clk) begin
      exp_t t;
      #2;
      if (sb.size() > 0) begin
         t = sb.pop_front();
         n_checks++;
         assert (w_obs === t.exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", t.tag, w_obs, t.exp);
         end
      end
   end

   initial begin
      st(1, 0, OP_R, 0, NONE, "reset_idle");
      st(1, 1, OP_R, 1, NONE, "reset_run_high");
      st(0, 0, OP_R, 1, NONE, "idle_run_low");

      st(0, 1, OP_R, 1, REQ | IRW | PCW, "r_fetch");
      st(0, 1, OP_R, 1, NONE,            "r_decode");
      st(0, 1, OP_R, 1, NONE,            "r_exec");
      st(0, 1, OP_R, 1, RW | RET,        "r_wb");

      st(0, 1, OP_LOAD, 1, REQ | IRW | PCW, "ld_fetch");
      st(0, 1, OP_LOAD, 0, NONE,            "ld_decode");
      st(0, 1, OP_LOAD, 0, ALUS,            "ld_exec");
      for (int i = 0; i < 3; i++) st(0, 1, OP_LOAD, 0, REQ | ASEL | ALUS, "ld_mem_wait");
      st(0, 1, OP_LOAD, 1, REQ | ASEL | ALUS, "ld_mem_done");
      st(0, 1, OP_LOAD, 0, RW | RET | M2R,    "ld_wb");

      st(0, 1, OP_STORE, 1, REQ | IRW | PCW, "st_fetch");
      st(0, 1, OP_STORE, 1, NONE,            "st_decode");
      st(0, 1, OP_STORE, 1, ALUS,            "st_exec");
      st(0, 1, OP_STORE, 1, REQ | WE | ASEL | ALUS | RET, "st_mem");

      st(0, 1, OP_BR, 1, REQ | IRW | PCW,   "br_fetch");
      st(0, 1, OP_BR, 1, NONE,              "br_decode");
      st(0, 1, OP_BR, 1, BRN | PCW | RET,   "br_exec");

      st(0, 1, OP_IALU, 1, REQ | IRW | PCW, "ialu_fetch");
      st(0, 1, OP_IALU, 1, NONE,            "ialu_decode");
      st(0, 1, OP_IALU, 1, ALUS,            "ialu_exec");
      st(0, 1, OP_IALU, 1, RW | RET,        "ialu_wb");

      st(0, 1, OP_R, 0, REQ,             "hold_fetch_first");
      st(0, 0, OP_R, 0, REQ,             "hold_fetch_run_low");
      st(0, 0, OP_R, 1, REQ | IRW | PCW, "hold_fetch_done");
      st(0, 0, OP_R, 1, NONE,            "hold_decode");
      st(0, 0, OP_R, 1, NONE,            "hold_exec");
      st(0, 0, OP_R, 1, RW | RET,        "hold_wb");
      st(0, 0, OP_R, 1, NONE,            "idle_ready_ignored");

      st(0, 1, OP_BAD, 1, REQ | IRW | PCW, "ill_fetch");
      st(0, 1, OP_BAD, 1, NONE,            "ill_decode");
      for (int i = 0; i < 20; i++) st(0, 1, OP_BAD, 1'(i), ILL | HLT, "ill_trap_hold");
      st(1, 1, OP_R, 0, NONE, "ill_reset");
      st(0, 0, OP_R, 0, NONE, "ill_cleared");

      for (int i = 0; i < 16; i++) st(0, 1, OP_R, 0, REQ, "to_fetch_wait");
      for (int i = 0; i < 3; i++)  st(0, 1, OP_R, 0, BERR | HLT, "to_trap");
      st(1, 0, OP_R, 0, NONE, "to_reset");

      for (int i = 0; i < 15; i++) st(0, 1, OP_R, 0, REQ, "edge_fetch_wait");
      st(0, 1, OP_R, 1, REQ | IRW | PCW, "edge_ready_wins");
      st(0, 1, OP_R, 0, NONE,            "edge_decode");
      st(0, 1, OP_R, 0, NONE,            "edge_exec");
      st(0, 1, OP_R, 0, RW | RET,        "edge_wb");

      st(0, 1, OP_LOAD, 1, REQ | IRW | PCW, "mr_fetch");
      st(0, 1, OP_LOAD, 0, NONE,            "mr_decode");
      st(0, 1, OP_LOAD, 0, ALUS,            "mr_exec");
      st(0, 1, OP_LOAD, 0, REQ | ASEL | ALUS, "mr_mem_wait1");
      st(0, 1, OP_LOAD, 0, REQ | ASEL | ALUS, "mr_mem_wait2");
      st(1, 1, OP_LOAD, 0, NONE, "mr_reset_drop");
      st(0, 0, OP_LOAD, 1, NONE, "mr_idle1");
      st(0, 0, OP_LOAD, 1, NONE, "mr_idle2");
      st(0, 1, OP_STORE, 0, REQ, "mr_run_fetch");
      st(0, 1, OP_STORE, 1, REQ | IRW | PCW, "mr_fetch_done");

      st(0, 1, OP_STORE, 0, NONE, "smto_decode");
      st(0, 1, OP_STORE, 0, ALUS, "smto_exec");
      for (int i = 0; i < 16; i++) st(0, 1, OP_STORE, 0, REQ | WE | ASEL | ALUS, "smto_mem_wait");
      st(0, 1, OP_STORE, 1, BERR | HLT, "smto_trap1");
      st(0, 1, OP_STORE, 1, BERR | HLT, "smto_trap2");

      @(negedge clk);
      #4;
      n_checks++;
      assert (sb.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
